imem_fetch_wide: RTL and testbench

//  Next-gen instruction memory for the OoO front end. Returns a bundle of FETCH_WIDTH

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_fetch_wide_if.sv | 28 ++
 rtl/imem_resp_fifo.sv | 65 ++++++
 rtl/imem_fetch_wide.sv | 110 +++++++++++
 tb/tb_imem_fetch_wide.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the wide instruction-fetch memory.
// The package holds the bundle layout and the request error rule.
package imem_pkg;

  localparam int XLEN            = 32;
  localparam int FETCH_WIDTH_MAX = 8;

  typedef struct packed {
    logic [XLEN-1:0]                 addr;
    logic                            err;
    logic [FETCH_WIDTH_MAX*XLEN-1:0] inst;
  } fetch_bundle_t;

  // A request is flagged if it is not word aligned, or if its last lane would run past the array.
  function automatic logic fetch_addr_err(input logic [XLEN-1:0] addr,
                                          input int unsigned     mem_words,
                                          input int unsigned     fetch_width);
    return (addr[1:0] != 2'b00) ||
           ({2'b00, addr[XLEN-1:2]} > XLEN'(mem_words - fetch_width));
  endfunction

endpackage

// File: rtl/imem_fetch_wide_if.sv
// Request/response bus between the front end (master) and the instruction memory (slave).
interface imem_fetch_wide_if
  import imem_pkg::*;
#(
  parameter int FETCH_WIDTH = 2
);

  logic                        req_valid;
  logic                        req_ready;
  logic [XLEN-1:0]             req_addr;
  logic                        flush;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [XLEN-1:0]             resp_addr;
  logic [FETCH_WIDTH*XLEN-1:0] resp_inst;
  logic                        resp_err;

  modport master (
    output req_valid, req_addr, flush, resp_ready,
    input  req_ready, resp_valid, resp_addr, resp_inst, resp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, resp_ready,
    output req_ready, resp_valid, resp_addr, resp_inst, resp_err
  );

endinterface

// File: rtl/imem_resp_fifo.sv
// Circular response FIFO with occupancy count and a synchronous clear.
// Head/tail wrap at DEPTH-1; push and pop together are legal when full or empty.
module imem_resp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_pop_data = r_mem[r_head];

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_tail] <= i_push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full && !i_pop));

endmodule

// File: rtl/imem_fetch_wide.sv
// Wide instruction memory: LATENCY-deep read pipeline feeding a response FIFO,
// with credit flow control so the pipeline never stalls and flush drains everything.
module imem_fetch_wide
  import imem_pkg::*;
#(
  parameter int    MEM_WORDS       = 16384,
  parameter string HEXFILE         = "prog.hex",
  parameter int    FETCH_WIDTH     = 2,
  parameter int    LATENCY         = 1,
  parameter int    RESP_FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  imem_fetch_wide_if.slave  bus
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int CRED_W = $clog2(RESP_FIFO_DEPTH + 1);
  localparam int INST_W = FETCH_WIDTH * XLEN;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic              err;
    logic [INST_W-1:0] inst;
  } bundle_t;

  logic [XLEN-1:0]    r_mem [MEM_WORDS];
  logic [LATENCY-1:0] r_pipe_vld;
  logic [LATENCY-1:0] r_pipe_err;
  logic [XLEN-1:0]    r_pipe_addr [LATENCY];
  logic [CRED_W-1:0]  r_credits;

  logic              w_fire;
  logic              w_pop;
  logic              w_req_err;
  logic [INST_W-1:0] w_rd_inst;
  bundle_t           w_push_data;
  bundle_t           w_head;
  logic [CRED_W-1:0] w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  assign bus.req_ready = !bus.flush && (r_credits < CRED_W'(RESP_FIFO_DEPTH));
  assign w_fire        = bus.req_valid && bus.req_ready;
  assign w_req_err     = fetch_addr_err(bus.req_addr, MEM_WORDS, FETCH_WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      r_pipe_err <= '0;
      for (int s = 0; s < LATENCY; s++) r_pipe_addr[s] <= '0;
    end else if (bus.flush) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0]  <= w_fire;
      r_pipe_err[0]  <= w_req_err;
      r_pipe_addr[0] <= bus.req_addr;
      for (int s = 1; s < LATENCY; s++) begin
        r_pipe_vld[s]  <= r_pipe_vld[s-1];
        r_pipe_err[s]  <= r_pipe_err[s-1];
        r_pipe_addr[s] <= r_pipe_addr[s-1];
      end
    end
  end

  // Lanes wrap modulo MEM_WORDS through the natural overflow of the IDX_W-bit index.
  // NOTE: the default before the loop keeps every bit assigned on every path, so no latch is inferred.
  always_comb begin
    w_rd_inst = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_rd_inst[i*XLEN +: XLEN] = r_mem[r_pipe_addr[LATENCY-1][IDX_W+1:2] + IDX_W'(i)];
    end
  end

  assign w_push_data = '{addr: r_pipe_addr[LATENCY-1], err: r_pipe_err[LATENCY-1], inst: w_rd_inst};

  imem_resp_fifo #(
    .DEPTH (RESP_FIFO_DEPTH),
    .WIDTH ($bits(bundle_t))
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (bus.flush),
    .i_push      (r_pipe_vld[LATENCY-1]),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign bus.resp_valid = !bus.flush && !w_fifo_empty;
  assign w_pop          = bus.resp_valid && bus.resp_ready;
  assign bus.resp_addr  = w_fifo_empty ? '0 : w_head.addr;
  assign bus.resp_err   = w_fifo_empty ? 1'b0 : w_head.err;
  assign bus.resp_inst  = w_fifo_empty ? '0 : w_head.inst;

  // A credit is taken on fire and only returned on the edge after a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_credits <= '0;
    else if (bus.flush)           r_credits <= '0;
    else if (w_fire && !w_pop)    r_credits <= r_credits + CRED_W'(1);
    else if (!w_fire && w_pop)    r_credits <= r_credits - CRED_W'(1);
  end

  a_credit_track: assert property (@(posedge clk) disable iff (rst)
    int'(r_credits) == $countones(r_pipe_vld) + int'(w_fifo_count));

endmodule

// File: tb/tb_imem_fetch_wide.sv
// Randomised and directed bench for imem_fetch_wide against a queue-based reference model.
module tb_imem_fetch_wide;
  import imem_pkg::*;

  localparam int MEM_WORDS = 16384;
  localparam int FW        = 2;
  localparam int LAT       = 1;
  localparam int DEPTH     = 4;

  typedef struct {
    fetch_bundle_t b;
    int            vis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] model_mem [MEM_WORDS];
  exp_t        model_q [$];
  int          edge_n   = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  imem_fetch_wide_if #(.FETCH_WIDTH(FW)) bus ();

  imem_fetch_wide #(
    .MEM_WORDS       (MEM_WORDS),
    .HEXFILE         (""),
    .FETCH_WIDTH     (FW),
    .LATENCY         (LAT),
    .RESP_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic fetch_bundle_t model_fetch(input logic [31:0] addr);
    fetch_bundle_t b;
    int unsigned   word;
    b      = '0;
    word   = addr >> 2;
    b.addr = addr;
    b.err  = (addr % 32'd4 != 0) || (word > MEM_WORDS - FW);
    for (int i = 0; i < FW; i++) b.inst[i*32 +: 32] = model_mem[(word + i) % MEM_WORDS];
    return b;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, MEM_WORDS - 1) << 2;
      1:       return $urandom_range(MEM_WORDS - 4, MEM_WORDS - 1) << 2;
      2:       return $urandom;
      default: return ($urandom_range(0, MEM_WORDS - 1) << 2) | $urandom_range(0, 3);
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, compare outputs, then advance the model at the rising edge.
  task automatic cycle(input logic rv, input logic [31:0] ra, input logic rr, input logic fl);
    logic exp_rq;
    logic exp_rv;
    logic fire;
    logic pop;
    exp_t e;
    @(negedge clk);
    bus.req_valid  = rv;
    bus.req_addr   = ra;
    bus.resp_ready = rr;
    bus.flush      = fl;
    #1;
    exp_rq = !fl && (model_q.size() < DEPTH);
    exp_rv = !fl && (model_q.size() != 0) && (model_q[0].vis <= edge_n);
    check("req_ready", 64'(bus.req_ready), 64'(exp_rq));
    check("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
    if (exp_rv) begin
      check("resp_addr", 64'(bus.resp_addr), 64'(model_q[0].b.addr));
      check("resp_err", 64'(bus.resp_err), 64'(model_q[0].b.err));
      check("resp_inst", 64'(bus.resp_inst), 64'(model_q[0].b.inst[FW*32-1:0]));
    end
    fire = rv && exp_rq;
    pop  = exp_rv && rr;
    @(posedge clk);
    edge_n++;
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (fire) begin
        e.b   = model_fetch(ra);
        e.vis = edge_n + LAT;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      model_mem[i] = $urandom;
      dut.r_mem[i] = model_mem[i];
    end
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.resp_ready = 1'b0;
    bus.flush      = 1'b0;

    #1 rst = 1'b1;
    #1;
    check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("rst_resp_addr", 64'(bus.resp_addr), 64'(0));
    check("rst_resp_inst", 64'(bus.resp_inst), 64'(0));
    check("rst_resp_err", 64'(bus.resp_err), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 64'(bus.req_ready), 64'(1));

    // Single request to word 0: bundle appears the cycle after the push edge.
    cycle(1'b1, 32'h0, 1'b1, 1'b0);
    drain(3);

    // Back-to-back sequential fetches with the consumer always ready.
    for (int k = 0; k < 12; k++) cycle(1'b1, 32'(k * 8), 1'b1, 1'b0);
    drain(3);

    // Consumer stalled: credits run out at DEPTH, one pop frees one credit.
    for (int k = 0; k < 6; k++) cycle(1'b1, 32'h200 + 32'(k * 8), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h300, 1'b0, 1'b0);
    drain(8);

    // Boundary addresses: last word wraps lane 1 to word 0, misaligned address errors.
    cycle(1'b1, 32'h0000_FFFC, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0002, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_FFF8, 1'b1, 1'b0);
    cycle(1'b1, 32'h8000_0000, 1'b1, 1'b0);
    drain(3);

    // Flush with responses buffered and in flight, then a fresh request.
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h400 + 32'(k * 8), 1'b0, 1'b0);
    cycle(1'b1, 32'h500, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h40, 1'b1, 1'b0);
    drain(3);

    // Flush held for several cycles while the front end keeps requesting.
    cycle(1'b1, 32'h600, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h700, 1'b1, 1'b1);
    cycle(1'b1, 32'h800, 1'b1, 1'b0);
    drain(3);

    // Asynchronous reset in the middle of a cycle with data buffered.
    cycle(1'b1, 32'h100, 1'b0, 1'b0);
    cycle(1'b1, 32'h108, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("midrst_resp_addr", 64'(bus.resp_addr), 64'(0));
    check("midrst_resp_inst", 64'(bus.resp_inst), 64'(0));
    model_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h0, 1'b1, 1'b0);
    drain(3);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 9) < 6,
            $urandom_range(0, 29) == 0);
    end
    drain(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
